counter_ctrl: RTL

Sequencing controller sitting directly upstream of the `counter` stage. It observes the counter's current value and drives the counter's `load`, `load_value` and `down` inputs every cycle, which gives the counter these features:
- free-running, range-wrapping and bouncing count modes;
- a valid/ready preset port;
- a pause;
- a wrap-event pulse and a saturating wrap tally.

---
 rtl/counter_pkg.sv | 14 +
 rtl/sat_counter.sv | 21 ++
 rtl/counter_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared encodings for the counter stage and its sequencing controller.
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_UP     = 2'b00,
        MODE_DOWN   = 2'b01,
        MODE_RANGE  = 2'b10,
        MODE_BOUNCE = 2'b11
    } mode_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of rolling over.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] value
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (inc && (value != '1)) begin
            value <= value + 1'b1;
        end
    end

endmodule

// File: rtl/counter_ctrl.sv
// Drives the counter's load/load_value/down each cycle to add count modes,
// a preset handshake, pause and boundary-event reporting on top of it.
module counter_ctrl
    import counter_pkg::*;
#(
    parameter int                   DATAWIDTH = 4,
    parameter logic [DATAWIDTH-1:0] START     = '0,
    parameter logic [DATAWIDTH-1:0] ENDING    = '1,
    parameter int                   WRAPW     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATAWIDTH-1:0] count_in,
    input  logic [1:0]           mode,
    input  logic                 pause,
    input  logic                 preset_valid,
    input  logic [DATAWIDTH-1:0] preset_value,
    output logic                 preset_ready,
    output logic                 load,
    output logic [DATAWIDTH-1:0] load_value,
    output logic                 down,
    output logic                 wrap_pulse,
    output logic [WRAPW-1:0]     wrap_cnt
);

    mode_e                mode_cur;
    mode_e                mode_q;
    logic                 dir_q;
    logic                 dir_d;
    logic                 event_d;
    logic                 accept;
    logic                 in_range;
    logic                 at_start;
    logic                 at_end;
    logic                 enter_bounce;
    logic [DATAWIDTH-1:0] preset_clamped;

    assign mode_cur     = mode_e'(mode);
    assign in_range     = (count_in >= START) && (count_in <= ENDING);
    assign at_start     = (count_in == START);
    assign at_end       = (count_in == ENDING);
    assign enter_bounce = (mode_cur == MODE_BOUNCE) && (mode_q != MODE_BOUNCE);

    assign preset_clamped = (preset_value < START)  ? START  :
                            (preset_value > ENDING) ? ENDING : preset_value;

    assign preset_ready = !rst && !pause;
    assign accept       = preset_valid && preset_ready;

    // NOTE: every output of this block gets a default before any branch,
    // so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        load       = 1'b0;
        load_value = START;
        down       = 1'b0;
        event_d    = 1'b0;
        dir_d      = dir_q;

        if (rst) begin
            // outputs stay at their quiet defaults while reset is held
        end else if (accept) begin
            load       = 1'b1;
            load_value = ((mode_cur == MODE_RANGE) || (mode_cur == MODE_BOUNCE))
                         ? preset_clamped : preset_value;
        end else if (pause) begin
            load       = 1'b1;
            load_value = count_in;
        end else begin
            unique case (mode_cur)
                MODE_UP: begin
                    event_d = &count_in;
                end
                MODE_DOWN: begin
                    down    = 1'b1;
                    event_d = (count_in == '0);
                end
                MODE_RANGE: begin
                    // Out-of-range values are pulled back silently; only
                    // reaching ENDING counts as a wrap.
                    if (!in_range) begin
                        load = 1'b1;
                    end else if (at_end) begin
                        load    = 1'b1;
                        event_d = 1'b1;
                    end
                end
                MODE_BOUNCE: begin
                    if (!in_range) begin
                        load  = 1'b1;
                        dir_d = DIR_UP;
                    end else if (at_end && (dir_q == DIR_UP)) begin
                        down    = 1'b1;
                        dir_d   = DIR_DOWN;
                        event_d = 1'b1;
                    end else if (at_start && (dir_q == DIR_DOWN)) begin
                        down    = 1'b0;
                        dir_d   = DIR_UP;
                        event_d = 1'b1;
                    end else begin
                        down = dir_q;
                    end
                end
                default: ;
            endcase
        end

        // Entering bounce always restarts upward, overriding any bound turn.
        if (enter_bounce) begin
            dir_d = DIR_UP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q     <= MODE_UP;
            dir_q      <= DIR_UP;
            wrap_pulse <= 1'b0;
        end else begin
            mode_q     <= mode_cur;
            dir_q      <= dir_d;
            wrap_pulse <= event_d;
        end
    end

    sat_counter #(
        .WIDTH (WRAPW)
    ) u_wrap_tally (
        .clk   (clk),
        .rst   (rst),
        .inc   (event_d),
        .value (wrap_cnt)
    );

endmodule
